prio_encoder_rr: RTL and testbench

//  Parametrised, registered successor to the team's 4-to-2 encoder. Takes N request lines.

---
 rtl/prio_pkg.sv | 16 +
 rtl/prio_encoder_rr_if.sv | 27 ++
 rtl/prio_pick.sv | 38 +++
 rtl/prio_encoder_rr.sv | 103 ++++++++++
 tb/tb_prio_encoder_rr.sv | 123 ++++++++++++
 5 files changed

// File: rtl/prio_pkg.sv
// Shared encodings for the registered priority / round-robin encoder.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package prio_pkg;

  // Selection mode as driven on the mode input.
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // IDLE: evaluating req every cycle. HOLD: presenting a captured index.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/prio_encoder_rr_if.sv
// Request/index bundle between request sources, the encoder and its consumer.
// Latency: none (wiring only).
// Backpressure: out_ready from the consumer stalls the encoder output.
interface prio_encoder_rr_if #(
  parameter int N = 8
);
  localparam int W = $clog2(N);

  logic [N-1:0] req;
  logic         mode;
  logic [W-1:0] out_idx;
  logic         out_valid;
  logic         out_ready;
  logic         out_none;

  // Environment side: drives requests, mode and consumer ready.
  modport master (
    output req, mode, out_ready,
    input  out_idx, out_valid, out_none
  );

  // Encoder side.
  modport slave (
    input  req, mode, out_ready,
    output out_idx, out_valid, out_none
  );
endinterface

// File: rtl/prio_pick.sv
// Combinational winner pick: highest set bit, or first set bit at/after start with wrap.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is used.
module prio_pick
  import prio_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  input  logic         mode,
  output logic [W-1:0] idx,
  output logic         any
);

  // Later loop iterations overwrite earlier ones, so the iteration order sets priority.
  always_comb begin
    int j;
    j   = 0;
    idx = '0;
    any = |req;
    if (mode == MODE_FIXED) begin
      // Ascending scan: the highest set bit is written last and wins.
      for (int i = 0; i < N; i++) begin
        if (req[i]) idx = W'(i);
      end
    end else begin
      // Descending distance from start: the nearest set bit at/after start wins.
      for (int k = N - 1; k >= 0; k--) begin
        j = int'(start) + k;
        if (j >= N) j = j - N;
        if (req[j]) idx = W'(j);
      end
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-line encoder: fixed (highest index) or round-robin pick, valid/ready output.
// Latency: 1 clock from req to out_valid; back-to-back one index per clock while accepted.
// Backpressure: out_ready low freezes out_idx/out_valid; the captured index is never revoked.
module prio_encoder_rr
  import prio_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  prio_encoder_rr_if.slave  bus
);

  state_t       state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic         vld_q, vld_d;
  logic         none_q, none_d;
  logic [W-1:0] ptr_q, ptr_d;

  logic         accept;
  logic [W-1:0] ptr_after;
  logic [W-1:0] pick_start;
  logic [W-1:0] pick_idx;
  logic         pick_any;

  assign accept = vld_q && bus.out_ready;

  // Pointer value once the held index is accepted in round-robin mode; N-1 wraps to 0.
  assign ptr_after = (idx_q == W'(N - 1)) ? '0 : idx_q + W'(1);

  // A back-to-back reload must already search from the advanced pointer,
  // otherwise a steady all-ones req would return the same index twice.
  assign pick_start = (accept && bus.mode == MODE_RR) ? ptr_after : ptr_q;

  prio_pick #(.N(N)) u_pick (
    .req   (bus.req),
    .start (pick_start),
    .mode  (bus.mode),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Next-state and next-register values; everything holds unless a branch says otherwise.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    vld_d   = vld_q;
    none_d  = none_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          idx_d   = pick_idx;
          vld_d   = 1'b1;
          none_d  = 1'b0;
          state_d = ST_HOLD;
        end else begin
          none_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          if (bus.mode == MODE_RR) ptr_d = ptr_after;
          if (pick_any) begin
            idx_d   = pick_idx;
            none_d  = 1'b0;
          end else begin
            vld_d   = 1'b0;
            none_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        vld_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      none_q  <= 1'b1;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      none_q  <= none_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.out_idx   = idx_q;
  assign bus.out_valid = vld_q;
  assign bus.out_none  = none_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr (N=8): hand-derived expectations queued at drive time.
// Latency: each expectation is popped one clock after its inputs are applied.
// Backpressure: exercised through out_ready stalls in the stimulus.
module tb_prio_encoder_rr;

  localparam int N = 8;

  logic clk;
  logic rst;

  prio_encoder_rr_if #(.N(N)) bus ();

  prio_encoder_rr #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       vld;
    logic [2:0] idx;
    logic       none;
    bit         chk_idx;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks;
  int   n_pass;

  // One comparison: count it, report a mismatch.
  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Apply one cycle of inputs, queue the expected registered outputs, then compare after the edge.
  task automatic step(input string tag, input logic r, input logic m, input logic [7:0] rq,
                      input logic rdy, input logic ev, input logic [2:0] ei, input logic en,
                      input bit ci);
    exp_t e;
    @(negedge clk);
    rst           = r;
    bus.mode      = m;
    bus.req       = rq;
    bus.out_ready = rdy;
    e.tag = tag; e.vld = ev; e.idx = ei; e.none = en; e.chk_idx = ci;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check_val({tag, "_queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_val({e.tag, "_valid"}, 32'(bus.out_valid), 32'(e.vld));
      check_val({e.tag, "_none"},  32'(bus.out_none),  32'(e.none));
      if (e.chk_idx) check_val({e.tag, "_idx"}, 32'(bus.out_idx), 32'(e.idx));
    end
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst           = 1'b1;
    bus.req       = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;

    // Reset, then idle with no requests.
    step("rst", 1, 0, 8'h00, 0, 0, 3'd0, 1, 1);
    for (int i = 0; i < 5; i++) step("idle", 0, 0, 8'h00, 0, 0, 3'd0, 1, 1);

    // Fixed priority, back-to-back, then drain to IDLE.
    step("fix_0a",   0, 0, 8'h0A, 1, 1, 3'd3, 0, 1);
    step("fix_81",   0, 0, 8'h81, 1, 1, 3'd7, 0, 1);
    step("fix_drain",0, 0, 8'h00, 1, 0, 3'd0, 1, 0);
    step("fix_zero", 0, 0, 8'h00, 1, 0, 3'd0, 1, 0);

    // Stall holds the captured index while req changes.
    step("stall_ld", 0, 0, 8'h04, 0, 1, 3'd2, 0, 1);
    for (int i = 0; i < 4; i++) step("stall_hold", 0, 0, 8'h80, 0, 1, 3'd2, 0, 1);
    step("stall_rel",0, 0, 8'h80, 1, 1, 3'd7, 0, 1);
    step("stall_end",0, 0, 8'h00, 1, 0, 3'd0, 1, 0);

    // Round-robin over all-ones: 0..7 then wrap 0,1.
    for (int i = 0; i < 10; i++) step("rr_ff", 0, 1, 8'hFF, 1, 1, 3'(i % 8), 0, 1);

    // Pointer at 2 -> 5; accept 5 -> pointer 6 -> wraps to 0; accept 0 -> 5.
    step("rr_20",    0, 1, 8'h20, 1, 1, 3'd5, 0, 1);
    step("rr_wrap",  0, 1, 8'h21, 1, 1, 3'd0, 0, 1);
    step("rr_next",  0, 1, 8'h21, 1, 1, 3'd5, 0, 1);
    // Single request wins regardless of pointer (pointer now 6).
    step("rr_single",0, 1, 8'h01, 1, 1, 3'd0, 0, 1);
    // Fixed-mode accept leaves the pointer alone.
    step("mix_fix",  0, 0, 8'h80, 1, 1, 3'd7, 0, 1);
    step("mix_rr",   0, 1, 8'h42, 1, 1, 3'd1, 0, 1);
    step("mix_fix2", 0, 0, 8'h42, 1, 1, 3'd6, 0, 1);
    step("mix_rr2",  0, 1, 8'h42, 1, 1, 3'd1, 0, 1);
    // Mode change while stalled does not alter the held index.
    step("mode_hold",0, 0, 8'h42, 0, 1, 3'd1, 0, 1);

    // Reset in HOLD discards the index; reload on the following edge.
    step("hold_3",   0, 0, 8'h08, 1, 1, 3'd3, 0, 1);
    step("hold_3s",  0, 1, 8'h08, 0, 1, 3'd3, 0, 1);
    step("rst_hold", 1, 1, 8'h08, 1, 0, 3'd0, 1, 1);
    step("post_rst", 0, 1, 8'h08, 0, 1, 3'd3, 0, 1);
    // Pointer cleared by reset: from 0 the pick of 0x81 is 0, then 7.
    step("ptr_drain",0, 0, 8'h00, 1, 0, 3'd0, 1, 0);
    step("ptr_zero", 0, 1, 8'h81, 0, 1, 3'd0, 0, 1);
    step("ptr_adv",  0, 1, 8'h81, 1, 1, 3'd7, 0, 1);
    step("final",    0, 1, 8'h00, 1, 0, 3'd0, 1, 0);

    if (exp_q.size() != 0) check_val("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
